// File: rtl/mmio_bus_bridge_pkg.sv
// Shared constants for the MMIO bus bridge: I/O window offsets, clear-FSM
// encoding and STATUS bit positions.
// Latency: n/a (constants only). Backpressure: n/a.
package mmio_bus_bridge_pkg;

    // Clear-engine state encoding (kept as plain vectors for legacy tools).
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // STATUS register bit holding the sticky "new capture" flag.
    localparam int CAP_NEW_BIT = 0;

    // Word offsets inside the I/O window, relative to IO_BASE.
    localparam int OFF_OUT = 0;

    function automatic int off_in(input int n_out);
        return n_out;
    endfunction

    function automatic int off_cap(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

    function automatic int off_stat(input int n_out, input int n_in,
                                    input int cap_w, input int dw);
        return n_out + n_in + cap_w / dw;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, one independent chain per bit.
// Latency: 2 clk cycles from d_i to q_o. Backpressure: none.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronised).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU data-bus decoder: RAM port B pass-through, MMIO window, RAM clear engine.
// Latency: reads return 1 cycle after the strobe; writes take effect at the strobe edge.
// Backpressure: none per access; cpu_stall freezes the CPU for the whole clear sweep.
// Ports: bus_* CPU side, ram_* RAM port B, out_regs/in_pins/cap_* I/O,
//        bus_clr/cpu_stall clear engine control; clk, res (async active-low).
module mmio_bus_bridge
    import mmio_bus_bridge_pkg::*;
#(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int RAM_DEPTH = 4096,
    parameter int IO_BASE   = 110,
    parameter int N_OUT     = 1,
    parameter int N_IN      = 1,
    parameter int CAP_W     = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [AW-1:0]     bus_addr,
    input  logic [DW-1:0]     bus_wdata,
    output logic [DW-1:0]     bus_rdata,
    input  logic              bus_clr,
    output logic              cpu_stall,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_rdata,
    output logic [N_OUT*DW-1:0] out_regs,
    input  logic [N_IN*DW-1:0]  in_pins,
    input  logic [CAP_W-1:0]  cap_code,
    input  logic              cap_valid
);

    localparam int CAP_WORDS = CAP_W / DW;
    localparam int OFF_IN_L   = off_in(N_OUT);
    localparam int OFF_CAP_L  = off_cap(N_OUT, N_IN);
    localparam int OFF_STAT_L = off_stat(N_OUT, N_IN, CAP_W, DW);
    localparam int IO_WORDS   = OFF_STAT_L + 1;

    localparam logic [AW-1:0] IO_BASE_A  = AW'(IO_BASE);
    localparam logic [AW-1:0] IO_WORDS_A = AW'(IO_WORDS);
    localparam logic [AW:0]   CNT_LAST   = (AW+1)'(RAM_DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

    // ---------------- clear engine ----------------
    logic [0:0]  state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        clearing;

    assign clearing = (state_q == ST_CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- address decode ----------------
    logic [AW-1:0] offset;
    logic          in_win;
    logic          acc_rd, acc_wr;

    assign offset = bus_addr - IO_BASE_A;
    assign in_win = (bus_addr >= IO_BASE_A) && (offset < IO_WORDS_A);
    // The CPU is frozen during a clear, so any strobe seen then is stale.
    assign acc_rd = bus_sel & ~bus_we & ~clearing;
    assign acc_wr = bus_sel &  bus_we & ~clearing;

    // RAM port B: clear sweep overrides the CPU; I/O words never reach RAM.
    always_comb begin
        if (clearing) begin
            ram_addr  = cnt_q[AW-1:0];
            ram_wdata = '0;
            ram_we    = 1'b1;
        end else begin
            ram_addr  = bus_addr;
            ram_wdata = bus_wdata;
            ram_we    = acc_wr & ~in_win;
        end
    end

    assign cpu_stall = clearing;

    // ---------------- I/O registers ----------------
    logic [N_OUT*DW-1:0] out_q, out_d;
    logic [N_IN*DW-1:0]  in_sync;
    logic [CAP_W-1:0]    cap_q;
    logic                cap_new_q, cap_new_d;
    logic                cap_valid_q;
    logic                cap_edge;
    logic                stat_clr;

    sync_2ff #(.W(N_IN*DW)) u_in_sync (
        .clk   (clk),
        .rst_n (res),
        .d_i   (in_pins),
        .q_o   (in_sync)
    );

    always_comb begin
        out_d = out_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (acc_wr && in_win && offset == AW'(OFF_OUT + k)) begin
                out_d[k*DW +: DW] = bus_wdata;
            end
        end
    end

    assign cap_edge = cap_valid & ~cap_valid_q;
    assign stat_clr = acc_wr && in_win && (offset == AW'(OFF_STAT_L))
                      && bus_wdata[CAP_NEW_BIT];
    // A capture in the same cycle as a clear request leaves the flag set.
    assign cap_new_d = cap_edge ? 1'b1 : (stat_clr ? 1'b0 : cap_new_q);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            out_q       <= '0;
            cap_q       <= '0;
            cap_new_q   <= 1'b0;
            cap_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            cap_new_q   <= cap_new_d;
            cap_valid_q <= cap_valid;
            if (cap_edge) begin
                cap_q <= cap_code;
            end
        end
    end

    assign out_regs = out_q;

    // I/O read mux; capture words are presented most-significant first.
    logic [DW-1:0] io_word;

    always_comb begin
        io_word = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (offset == AW'(OFF_OUT + k)) io_word = out_q[k*DW +: DW];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (offset == AW'(OFF_IN_L + k)) io_word = in_sync[k*DW +: DW];
        end
        for (int k = 0; k < CAP_WORDS; k++) begin
            if (offset == AW'(OFF_CAP_L + k)) io_word = cap_q[(CAP_WORDS-1-k)*DW +: DW];
        end
        if (offset == AW'(OFF_STAT_L)) io_word[CAP_NEW_BIT] = cap_new_q;
    end

    // ---------------- read path ----------------
    // rd_pend_q marks the cycle after a read strobe, when ram_rdata is live;
    // hold_q keeps the returned word stable until the next read.
    logic          rd_pend_q;
    logic          rd_io_q;
    logic [DW-1:0] io_rdata_q;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] rd_mux;

    assign rd_mux    = rd_io_q ? io_rdata_q : ram_rdata;
    assign bus_rdata = rd_pend_q ? rd_mux : hold_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rd_pend_q  <= 1'b0;
            rd_io_q    <= 1'b0;
            io_rdata_q <= '0;
            hold_q     <= '0;
        end else begin
            rd_pend_q <= acc_rd;
            if (acc_rd) begin
                rd_io_q    <= in_win;
                io_rdata_q <= io_word;
            end
            if (rd_pend_q) begin
                hold_q <= rd_mux;
            end
        end
    end

endmodule

// File: doc/mmio_bus_bridge.md
Name: mmio_bus_bridge

Overview:
- Parametrised successor to the CPU data-bus decoder in the top level.
- Sits between the CPU data port and RAM port B; owns the memory-mapped I/O window: output registers (digital-tube class), synchronised input ports (button class) and a multi-word capture register with a sticky new flag (IR-code class).
- Provides a RAM clear engine that stalls the CPU while it zeroes RAM.
- Registered read path with a fixed 1-cycle latency for both RAM and I/O.

Parameters:
- AW, 12, bus/RAM address width.
- DW, 16, data word width.
- RAM_DEPTH, 4096, words cleared by the clear engine; must be ≤ 2^AW.
- IO_BASE, 110, first address of the I/O window.
- N_OUT, 1, number of read/write output registers.
- N_IN, 1, number of read-only input ports.
- CAP_W, 32, capture width; must be a multiple of DW.

Ports:
- clk  in  1  system clock.
- res  in  1  reset, asynchronous, active-low.
- bus_sel  in  1  CPU access strobe, one cycle per access.
- bus_we  in  1  1 = write, 0 = read; qualified by bus_sel.
- bus_addr  in  AW  word address.
- bus_wdata  in  DW  write data.
- bus_rdata  out  DW  read data, valid the cycle after a read strobe.
- bus_clr  in  1  one-cycle request to start a RAM clear.
- cpu_stall  out  1  CPU clock-enable kill, high during clear.
- ram_addr  out  AW  RAM port B address.
- ram_wdata  out  DW  RAM port B write data.
- ram_we  out  1  RAM port B write enable.
- ram_rdata  in  DW  RAM port B synchronous read data (1-cycle).
- out_regs  out  N_OUT*DW  output registers; word k at bits [k*DW +: DW].
- in_pins  in  N_IN*DW  asynchronous input ports.
- cap_code  in  CAP_W  capture data.
- cap_valid  in  1  capture strobe, synchronous to clk; level-to-pulse done internally.

Behaviour:
- Address map, with offset = bus_addr − IO_BASE:
  - 0..N_OUT−1: out_regs, RW.
  - N_OUT..N_OUT+N_IN−1: synchronised in_pins, RO.
  - next CAP_W/DW words: capture register, most-significant word first, RO.
  - next word: STATUS, where bit0 = cap_new and all other bits read 0.
  - Default map: 110 out, 111 in, 112 cap[31:16], 113 cap[15:0], 114 status.
- I/O window words shadow RAM. Accesses there never assert ram_we. Writes to RO words are dropped.
- Outside the window:
  - ram_addr = bus_addr, ram_wdata = bus_wdata, ram_we = bus_sel & bus_we, all combinational.
- Read latency: exactly 1 cycle.
  - On a read strobe, register the source select (RAM/IO) and the IO data.
  - bus_rdata is then the mux of ram_rdata or the registered IO word.
  - bus_rdata holds its value until the next read; its reset value is 0.
- in_pins pass through a 2-FF synchroniser per bit. Reads return the second-stage value.
- Capture:
  - A rising edge of cap_valid (edge detected against a registered copy) loads the capture register and sets cap_new.
  - Writing STATUS with bit0 = 1 clears cap_new.
  - If an edge and a clear occur in the same cycle, the capture wins and cap_new = 1.
  - Capture continues while a clear is in progress.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on bus_clr.
  - In CLEAR: cpu_stall = 1, ram_we = 1, ram_wdata = 0, ram_addr = counter. The counter starts at 0, increments each cycle and ends at RAM_DEPTH−1, giving exactly RAM_DEPTH write cycles.
  - After the last write, return to IDLE; cpu_stall drops in the following cycle.
  - bus_sel and bus_clr are ignored in CLEAR.
  - The counter is AW+1 bits wide to avoid wrap at RAM_DEPTH = 2^AW.
  - out_regs and the capture register are untouched by a clear.
- Reset (res low, asynchronous):
  - Clears out_regs, capture register, cap_new, synchronisers, bus_rdata, counter.
  - FSM goes to IDLE; cpu_stall = 0, ram_we = 0.
  - Reset during CLEAR aborts the clear; RAM contents are then undefined.
- A bus_sel and bus_clr in the same IDLE cycle: the access completes and the clear starts in the next cycle.

Decomposition:
- Shared package holds:
  - Offset constants: OFF_OUT = 0, OFF_IN = N_OUT, OFF_CAP = N_OUT+N_IN, OFF_STAT = OFF_CAP+CAP_W/DW, computed as localparams from the parameters.
  - Clear-FSM state encoding (IDLE = 0, CLEAR = 1).
  - STATUS bit index (CAP_NEW_BIT = 0).
- One sub-module: sync_2ff (parametrised width), instantiated for in_pins.

Test Plan:
- Reset, then write 0xBEEF to 110 and read 110 → out_regs = 0xBEEF; bus_rdata = 0xBEEF one cycle after the read strobe; ram_we stays 0 throughout.
- Hold in_pins = 0x000A, wait 2 cycles, read 111 → 0x000A. Changing in_pins reads the old value for 2 cycles, then the new value.
- Pulse cap_valid with cap_code = 0x12345678 → read 112 = 0x1234, 113 = 0x5678, 114 = 0x0001. Write 114 = 1 → then read 114 = 0x0000. Repeat with the cap_valid edge in the same cycle as the clear write → 114 reads 0x0001.
- Write 0x55AA to 200, read 200 → 0x55AA arrives 1 cycle after the strobe. Write to 112 → RAM[112] unchanged, capture register unchanged.
- Pulse bus_clr with RAM_DEPTH = 16 → cpu_stall high for exactly 16 cycles, ram_addr sweeps 0..15 with ram_we = 1 and data 0, then the FSM is back in IDLE. out_regs keeps 0xBEEF.
- Assert res at clear cycle 5 → cpu_stall and ram_we drop immediately; after release, bus_clr restarts the clear from address 0.
